// File: rtl/sid_pkg.sv
// sid_pkg: shared SID register-write widths and write-entry type
package sid_pkg;
    localparam int SID_ADDR_W = 5;
    localparam int SID_DATA_W = 8;
    typedef struct packed {
        logic [SID_ADDR_W-1:0] addr;
        logic [SID_DATA_W-1:0] data;
    } sid_wr_t;
endpackage

// File: rtl/sid_wr_fifo.sv
// sid_wr_fifo: single-clock FIFO buffering one requester's SID writes
module sid_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 13
)(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_ovf_set
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count;
    logic          w_push;
    // a pop frees a slot on the same edge, so a full FIFO still accepts a push alongside it
    assign w_push    = i_push && (!o_full || i_pop);
    assign o_full    = r_count == (AW+1)'(DEPTH);
    assign o_empty   = r_count == '0;
    assign o_ovf_set = i_push && o_full && !i_pop;
    assign o_dout    = r_mem[r_rp];
    // pointer and occupancy bookkeeping
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            r_wp    <= r_wp + AW'(w_push);
            r_rp    <= r_rp + AW'(i_pop);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(i_pop);
        end
    end
    // entry storage needs no reset; the count guards reads
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end
endmodule

// File: rtl/sid_write_arbiter.sv
// sid_write_arbiter: round-robin sharing of the SID write port between bus (A) and SPI (B)
module sid_write_arbiter
    import sid_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SID_ADDR_W,
    parameter int DATA_W = SID_DATA_W
)(
    input  logic              i_sys_clk,
    input  logic              i_rst_n,
    input  logic              i_clk_en,
    input  logic              i_a_wr,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_data,
    output logic              o_a_full,
    output logic              o_a_ovf,
    input  logic              i_b_wr,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_data,
    output logic              o_b_full,
    output logic              o_b_ovf,
    input  logic              i_clr_ovf,
    output logic              o_sid_wr,
    output logic [ADDR_W-1:0] o_sid_addr,
    output logic [DATA_W-1:0] o_sid_data,
    output logic              o_grant_b
);
    sid_wr_t w_a_in, w_b_in, w_a_dout, w_b_dout, r_sid;
    logic    w_a_empty, w_b_empty, w_a_ovf_set, w_b_ovf_set;
    logic    w_issue, w_pick_b, w_pop_a, w_pop_b;
    logic    r_sid_wr, r_grant_b, r_a_ovf, r_b_ovf;
    assign w_a_in = '{addr: i_a_addr, data: i_a_data};
    assign w_b_in = '{addr: i_b_addr, data: i_b_data};
    sid_wr_fifo #(.DEPTH(DEPTH), .W($bits(sid_wr_t))) u_fifo_a (
        .i_clk(i_sys_clk), .i_rst_n(i_rst_n), .i_push(i_a_wr), .i_din(w_a_in),
        .i_pop(w_pop_a), .o_dout(w_a_dout), .o_full(o_a_full), .o_empty(w_a_empty),
        .o_ovf_set(w_a_ovf_set)
    );
    sid_wr_fifo #(.DEPTH(DEPTH), .W($bits(sid_wr_t))) u_fifo_b (
        .i_clk(i_sys_clk), .i_rst_n(i_rst_n), .i_push(i_b_wr), .i_din(w_b_in),
        .i_pop(w_pop_b), .o_dout(w_b_dout), .o_full(o_b_full), .o_empty(w_b_empty),
        .o_ovf_set(w_b_ovf_set)
    );
    // B wins when it alone has data, or both have data and A was served last
    assign w_pick_b = !w_b_empty && (w_a_empty || !r_grant_b);
    assign w_issue  = i_clk_en && (!w_a_empty || !w_b_empty);
    assign w_pop_a  = w_issue && !w_pick_b;
    assign w_pop_b  = w_issue && w_pick_b;
    // issue register, grant memory and sticky overflow flags (set beats clear)
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            r_sid_wr  <= 1'b0;
            r_sid     <= '0;
            r_grant_b <= 1'b1;
            r_a_ovf   <= 1'b0;
            r_b_ovf   <= 1'b0;
        end else begin
            r_sid_wr <= w_issue;
            if (w_issue) begin
                r_sid     <= w_pick_b ? w_b_dout : w_a_dout;
                r_grant_b <= w_pick_b;
            end
            r_a_ovf <= w_a_ovf_set || (r_a_ovf && !i_clr_ovf);
            r_b_ovf <= w_b_ovf_set || (r_b_ovf && !i_clr_ovf);
        end
    end
    assign o_sid_wr   = r_sid_wr;
    assign o_sid_addr = r_sid.addr;
    assign o_sid_data = r_sid.data;
    assign o_grant_b  = r_grant_b;
    assign o_a_ovf    = r_a_ovf;
    assign o_b_ovf    = r_b_ovf;
endmodule
